// File: rtl/conj_mon_pkg.sv
// Shared definitions for the req/gnt conjunction delay monitor: delay limits,
// the per-attempt outcome encoding and the saturating counter helper.
package conj_mon_pkg;

    localparam int MAX_DLY = 16;
    localparam int MAX_CH  = 32;
    localparam int MAX_CNT_W = 32;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } outcome_t;

    // Increment by one unless the value already sits at its ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        logic [31:0] res_s;
        if (val >= max_val) begin
            res_s = val;
        end else begin
            res_s = val + 32'd1;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/conj_mon_chan.sv
// One monitor channel: tracks every launched attempt through an alive shift
// register, checks gnt at both obligation ages, and keeps the channel's
// pulses, sticky failure flag and saturating pass/fail counters.
module conj_mon_chan
    import conj_mon_pkg::*;
#(
    parameter int DLY_A = 1,
    parameter int DLY_B = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req,
    input  logic             gnt,
    input  logic             sticky_clr,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << CNT_W) - 32'd1);

    // Bit k set: an attempt launched k+1 cycles ago is still pending.
    logic [DLY_B-1:0] alive_r;
    logic [DLY_B-1:0] alive_nxt_s;
    logic             launch_s;
    outcome_t         outcome_a_s;
    outcome_t         outcome_b_s;
    logic             pass_s;
    logic             fail_s;

    logic             pass_pulse_r;
    logic             fail_pulse_r;
    logic             fail_sticky_r;
    logic [CNT_W-1:0] pass_cnt_r;
    logic [CNT_W-1:0] fail_cnt_r;

    assign launch_s = req & enable;

    // Judge the attempts that reach either obligation age this cycle.
    always_comb begin
        outcome_a_s = NONE;
        outcome_b_s = NONE;
        if (alive_r[DLY_A-1] && !gnt) begin
            outcome_a_s = FAIL;
        end else begin
            outcome_a_s = NONE;
        end
        if (alive_r[DLY_B-1]) begin
            if (gnt) begin
                outcome_b_s = PASS;
            end else begin
                outcome_b_s = FAIL;
            end
        end else begin
            outcome_b_s = NONE;
        end
    end

    // Both checks see the same gnt, so pass and a first-stage fail exclude
    // each other; two fails in one cycle merge into a single pulse.
    always_comb begin
        pass_s = 1'b0;
        fail_s = 1'b0;
        case (outcome_b_s)
            PASS:    pass_s = 1'b1;
            FAIL:    fail_s = 1'b1;
            default: pass_s = 1'b0;
        endcase
        if (outcome_a_s == FAIL) begin
            fail_s = 1'b1;
        end else begin
            fail_s = fail_s;
        end
    end

    // Age every attempt by one; an attempt failing its first check is killed.
    always_comb begin
        alive_nxt_s        = {alive_r[DLY_B-2:0], launch_s};
        alive_nxt_s[DLY_A] = alive_r[DLY_A-1] & gnt;
    end

    // Alive pipeline register; reset drops in-flight attempts silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            alive_r <= '0;
        end else begin
            alive_r <= alive_nxt_s;
        end
    end

    // Register the outcome pulses one cycle after the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_pulse_r <= 1'b0;
            fail_pulse_r <= 1'b0;
        end else begin
            pass_pulse_r <= pass_s;
            fail_pulse_r <= fail_s;
        end
    end

    // Sticky failure flag: a visible fail pulse wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_sticky_r <= 1'b0;
        end else begin
            fail_sticky_r <= fail_pulse_r | (fail_sticky_r & ~sticky_clr);
        end
    end

    // Saturating counters advance on each visible pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_r <= '0;
            fail_cnt_r <= '0;
        end else begin
            if (pass_pulse_r) begin
                pass_cnt_r <= CNT_W'(sat_inc(32'(pass_cnt_r), CNT_MAX));
            end else begin
                pass_cnt_r <= pass_cnt_r;
            end
            if (fail_pulse_r) begin
                fail_cnt_r <= CNT_W'(sat_inc(32'(fail_cnt_r), CNT_MAX));
            end else begin
                fail_cnt_r <= fail_cnt_r;
            end
        end
    end

    assign pass_pulse  = pass_pulse_r;
    assign fail_pulse  = fail_pulse_r;
    assign fail_sticky = fail_sticky_r;
    assign pass_cnt    = pass_cnt_r;
    assign fail_cnt    = fail_cnt_r;

endmodule

// File: rtl/conj_delay_monitor.sv
// Multi-channel req/gnt monitor: each request requires gnt high both DLY_A
// and DLY_B cycles later. Instantiates one conj_mon_chan per channel and
// packs the per-channel counters into flat buses.
module conj_delay_monitor
    import conj_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DLY_A  = 1,
    parameter int DLY_B  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       gnt,
    input  logic [NUM_CH-1:0]       sticky_clr,
    output logic [NUM_CH-1:0]       pass_pulse,
    output logic [NUM_CH-1:0]       fail_pulse,
    output logic [NUM_CH-1:0]       fail_sticky,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt
);

    // Reject unusable parameter sets while elaborating.
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $fatal(1, "conj_delay_monitor: NUM_CH must be 1..32");
    end
    if (DLY_A < 1 || DLY_A >= DLY_B) begin : g_bad_dly_a
        $fatal(1, "conj_delay_monitor: need 1 <= DLY_A < DLY_B");
    end
    if (DLY_B > MAX_DLY) begin : g_bad_dly_b
        $fatal(1, "conj_delay_monitor: DLY_B must not exceed 16");
    end
    if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
        $fatal(1, "conj_delay_monitor: CNT_W must be 1..32");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        conj_mon_chan #(
            .DLY_A (DLY_A),
            .DLY_B (DLY_B),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable),
            .req         (req[i]),
            .gnt         (gnt[i]),
            .sticky_clr  (sticky_clr[i]),
            .pass_pulse  (pass_pulse[i]),
            .fail_pulse  (fail_pulse[i]),
            .fail_sticky (fail_sticky[i]),
            .pass_cnt    (pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt    (fail_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_conj_delay_monitor.sv
// Self-checking bench for conj_delay_monitor. A reference model tracks each
// attempt by its launch cycle and judges it from the obligation rules; the
// expected outputs for the next cycle go into a queue that a separate
// monitor drains and compares against the DUT.
module tb_conj_delay_monitor;

    localparam int NUM_CH  = 4;
    localparam int DLY_A   = 2;
    localparam int DLY_B   = 5;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       gnt;
    logic [NUM_CH-1:0]       sticky_clr;
    logic [NUM_CH-1:0]       pass_pulse;
    logic [NUM_CH-1:0]       fail_pulse;
    logic [NUM_CH-1:0]       fail_sticky;
    logic [NUM_CH*CNT_W-1:0] pass_cnt;
    logic [NUM_CH*CNT_W-1:0] fail_cnt;

    conj_delay_monitor #(
        .NUM_CH (NUM_CH),
        .DLY_A  (DLY_A),
        .DLY_B  (DLY_B),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .gnt         (gnt),
        .sticky_clr  (sticky_clr),
        .pass_pulse  (pass_pulse),
        .fail_pulse  (fail_pulse),
        .fail_sticky (fail_sticky),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                      cyc;
        logic [NUM_CH-1:0]       pass;
        logic [NUM_CH-1:0]       fail;
        logic [NUM_CH-1:0]       sticky;
        logic [NUM_CH*CNT_W-1:0] pcnt;
        logic [NUM_CH*CNT_W-1:0] fcnt;
    } exp_t;

    typedef struct {
        int ch;
        int t;
    } att_t;

    exp_t exp_q[$];
    att_t pend[$];

    // Model state: what the DUT is expected to show in the current cycle.
    logic [NUM_CH-1:0] m_pass   = '0;
    logic [NUM_CH-1:0] m_fail   = '0;
    logic [NUM_CH-1:0] m_sticky = '0;
    int                m_pcnt[NUM_CH];
    int                m_fcnt[NUM_CH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int c, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
        end
    endtask

    // Advance one cycle: drive inputs, then predict the outputs of the next cycle.
    task automatic step(input logic r, input logic e, input logic [NUM_CH-1:0] rq,
                        input logic [NUM_CH-1:0] g, input logic [NUM_CH-1:0] cl);
        exp_t              x;
        att_t              keep[$];
        logic [NUM_CH-1:0] np;
        logic [NUM_CH-1:0] nf;
        int                age;
        @(posedge clk);
        #1;
        rst        = r;
        enable     = e;
        req        = rq;
        gnt        = g;
        sticky_clr = cl;
        np = '0;
        nf = '0;
        if (r) begin
            pend.delete();
            m_sticky = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_pcnt[ch] = 0;
                m_fcnt[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (m_pass[ch] && m_pcnt[ch] < CNT_MAX) m_pcnt[ch]++;
                if (m_fail[ch] && m_fcnt[ch] < CNT_MAX) m_fcnt[ch]++;
                m_sticky[ch] = m_fail[ch] | (m_sticky[ch] & ~cl[ch]);
            end
            foreach (pend[i]) begin
                age = cyc - pend[i].t;
                if (age == DLY_A && !g[pend[i].ch]) begin
                    nf[pend[i].ch] = 1'b1;
                end else if (age == DLY_B) begin
                    if (g[pend[i].ch]) np[pend[i].ch] = 1'b1;
                    else               nf[pend[i].ch] = 1'b1;
                end else begin
                    keep.push_back(pend[i]);
                end
            end
            pend = keep;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (rq[ch] && e) pend.push_back('{ch, cyc});
            end
        end
        m_pass = np;
        m_fail = nf;
        x.cyc    = cyc + 1;
        x.pass   = m_pass;
        x.fail   = m_fail;
        x.sticky = m_sticky;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            x.pcnt[ch*CNT_W +: CNT_W] = CNT_W'(m_pcnt[ch]);
            x.fcnt[ch*CNT_W +: CNT_W] = CNT_W'(m_fcnt[ch]);
        end
        exp_q.push_back(x);
    endtask

    // Monitor: pop the expectation due this cycle and compare all outputs.
    exp_t mon_x;
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("stale_expectation", cyc, 64'(exp_q[0].cyc), 64'(cyc));
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_x = exp_q.pop_front();
            chk("pass_pulse",  cyc, 64'(pass_pulse),  64'(mon_x.pass));
            chk("fail_pulse",  cyc, 64'(fail_pulse),  64'(mon_x.fail));
            chk("fail_sticky", cyc, 64'(fail_sticky), 64'(mon_x.sticky));
            chk("pass_cnt",    cyc, 64'(pass_cnt),    64'(mon_x.pcnt));
            chk("fail_cnt",    cyc, 64'(fail_cnt),    64'(mon_x.fcnt));
        end
    end

    logic [NUM_CH-1:0] rr;
    logic [NUM_CH-1:0] gg;
    logic [NUM_CH-1:0] cc;

    initial begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_pcnt[ch] = 0;
            m_fcnt[ch] = 0;
        end
        rst        = 1'b1;
        enable     = 1'b0;
        req        = '0;
        gnt        = '0;
        sticky_clr = '0;

        // Reset state.
        step(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);

        // Single request on ch0 with gnt at both obligation ages: pass.
        step(1'b0, 1'b1, 4'h1, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h1, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h1, 4'h0);
        repeat (3) step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);

        // Request on ch0 with gnt only at the late age: early fail, no second report.
        step(1'b0, 1'b1, 4'h1, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h1, 4'h0);
        repeat (3) step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);

        // Held request on ch1 with gnt held: back-to-back passes.
        repeat (5) step(1'b0, 1'b1, 4'h2, 4'h2, 4'h0);
        repeat (7) step(1'b0, 1'b1, 4'h0, 4'h2, 4'h0);

        // Ch2 failures, clear coinciding with a new fail pulse, then clear alone.
        step(1'b0, 1'b1, 4'h4, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h4, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h4);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h4);
        step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);

        // Launches blocked while disabled; gnt with nothing pending is ignored.
        repeat (8) step(1'b0, 1'b0, 4'h4, 4'h0, 4'h0);
        repeat (4) step(1'b0, 1'b0, 4'h0, 4'hF, 4'h0);

        // Enable drop mid-flight: pending attempts still resolve.
        step(1'b0, 1'b1, 4'h8, 4'h0, 4'h0);
        repeat (7) step(1'b0, 1'b0, 4'h8, 4'h8, 4'h0);

        // Saturation: many failing attempts on every channel.
        repeat (20) step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0);
        repeat (6) step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);

        // Reset with attempts in flight: nothing reports afterwards.
        step(1'b0, 1'b1, 4'hF, 4'hF, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'hF, 4'h0);
        step(1'b1, 1'b1, 4'h0, 4'hF, 4'h0);
        repeat (8) step(1'b0, 1'b1, 4'h0, 4'hF, 4'h0);

        // Randomized traffic with occasional reset, disable and clear.
        for (int n = 0; n < 1500; n++) begin
            rr = 4'($urandom);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                gg[ch] = ($urandom_range(0, 3) != 0);
                cc[ch] = ($urandom_range(0, 7) == 0);
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), rr, gg, cc);
        end

        repeat (DLY_B + 2) step(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
